alu_exec_unit: RTL and testbench
================================

# alu_exec_unit

Multi-cycle execution unit that consumes the 4-bit ALU control code produced by the ALU control decoder and performs the selected operation on two operands. Logic ops and add/sub finish in one cycle; shifts iterate one bit per cycle to keep the datapath small. It sits in the execute stage behind the decoder and uses a valid/ready handshake on both sides so the sequencer can stall on it.

## Interface
- WIDTH, 32, operand/result width; power of two, ≥ 8.
- SHW, $clog2(WIDTH), shift-amount width, derived.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept a request.
- alu_ctl  in  4  ALU control code.
- op_a  in  WIDTH  first operand; the shifted value for shifts.
- op_b  in  WIDTH  second operand; bits [SHW-1:0] give the shift amount.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  operation result.
- zero  out  1  result == 0.
- illegal  out  1  alu_ctl was not a supported code.

## Operation
- Codes: 0010 add, 0110 sub, 0000 and, 0001 or, 1000 sll, 1001 srl, 1011 sra. Any other code, including 1111, is illegal.
- Add/sub wrap modulo 2^WIDTH; no carry or overflow output.
- Shift amount is op_b[SHW-1:0]; upper bits of op_b are ignored. sra replicates op_a[WIDTH-1].
- Illegal code: result=0, zero=1, illegal=1, completes like a one-cycle op.
- FSM states:
  - IDLE: in_ready=1. On accept, capture operands, code, and shift count. Add/sub/and/or/illegal → DONE with result registered. Shift with count 0 → DONE with result=op_a. Shift with count >0 → SHIFT.
  - SHIFT: shift the working register 1 bit and decrement the count each cycle. The cycle the count reaches 0 → DONE.
  - DONE: out_valid=1; result, zero and illegal are held stable. When out_ready=1 → IDLE.
- in_ready is low in SHIFT and DONE; in_valid there is ignored. No accept in the same cycle as a DONE→IDLE return.
- zero and illegal are registered together with result.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, zero=0, illegal=0, internal count=0.
- An accept at edge T, for a one-cycle op, raises out_valid after edge T+1. A shift by n raises out_valid after edge T+1+n; the worst case is WIDTH-1 extra cycles.
- Throughput: at most one op every 2 cycles, since DONE plus out_ready returns to IDLE and the next accept is one cycle later.
- out_valid stays high with all outputs frozen while out_ready=0, for any duration.
- If reset asserts in any state, it takes effect immediately (asynchronous). The in-flight op is discarded and no out_valid pulse follows.
- Inputs are sampled only on an accept edge. Later changes to op_a, op_b or alu_ctl do not affect the op in flight.

## Structure
- Shared package alu_pkg:
  - localparams for the seven ALU control codes plus ALU_ILLEGAL=4'b1111, shared with the decoder;
  - the FSM state type {IDLE, SHIFT, DONE}.
- One natural sub-module, alu_shift_step: purely combinational, one-bit sll/srl/sra of a WIDTH-bit value selected by a 2-bit kind. It is instantiated once on the working register.
- The single-cycle op mux stays in the top module.

## Test plan
- Add/sub: ctl=0010, a=7, b=5 → result=12, zero=0 one cycle after accept. ctl=0110, a=5, b=5 → result=0, zero=1. ctl=0110, a=0, b=1 → result=0xFFFFFFFF.
- Shifts: ctl=1000, a=1, b=31 → out_valid 32 cycles after accept, result=0x80000000. ctl=1011, a=0x80000000, b=4 → 0xF8000000. ctl=1001, same a/b → 0x08000000. ctl=1001, b=0x20 (amount 0) → result=a after 1 cycle.
- Illegal: ctl=1111 and ctl=0101 → result=0, zero=1, illegal=1, one-cycle latency.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → outputs stable and in_ready=0 throughout. in_valid pulses during SHIFT/DONE are not accepted.
- Reset mid-op: start sll by 20, assert reset at cycle 5 → immediately IDLE, out_valid=0, result=0. Next op ctl=0001, a=0xF0, b=0x0F → result=0xFF.
- Back-to-back: and (0x0F & 0x3C=0x0C), then or, with out_ready=1 tied → accepts spaced exactly 2 cycles apart, results in order.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, shift kinds and execute FSM states.
// Latency: none; this package only holds types, constants and helpers.
// Backpressure: not applicable.
package alu_pkg;

  // ALU control codes produced by the decoder
  localparam logic [3:0] ALU_AND     = 4'b0000;
  localparam logic [3:0] ALU_OR      = 4'b0001;
  localparam logic [3:0] ALU_ADD     = 4'b0010;
  localparam logic [3:0] ALU_SUB     = 4'b0110;
  localparam logic [3:0] ALU_SLL     = 4'b1000;
  localparam logic [3:0] ALU_SRL     = 4'b1001;
  localparam logic [3:0] ALU_SRA     = 4'b1011;
  localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

  // One-bit shift kinds; these equal the low two bits of the shift codes
  localparam logic [1:0] SK_SLL = 2'b00;
  localparam logic [1:0] SK_SRL = 2'b01;
  localparam logic [1:0] SK_SRA = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } alu_state_t;

  function automatic logic is_shift_code(input logic [3:0] ctl);
    return (ctl == ALU_SLL) || (ctl == ALU_SRL) || (ctl == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_shift_step.sv
// Single-bit shifter: sll/srl/sra of a WIDTH-bit value by exactly one position.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the output.
module alu_shift_step
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] din,
  input  logic [1:0]       kind,
  output logic [WIDTH-1:0] dout
);

  // Select one-bit shift; the unused kind passes the value through unchanged
  always_comb begin
    dout = din;
    case (kind)
      SK_SLL:  dout = {din[WIDTH-2:0], 1'b0};
      SK_SRL:  dout = {1'b0, din[WIDTH-1:1]};
      SK_SRA:  dout = {din[WIDTH-1], din[WIDTH-1:1]};
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU execute stage: add/sub/and/or in one step, shifts one bit per cycle.
// Latency: 1 cycle after accept for one-cycle ops and illegal codes; 1+n cycles for a shift by n.
// Backpressure: result held in DONE until out_ready; in_ready is low outside IDLE.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam int SHW = $clog2(WIDTH);

  alu_state_t       state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [1:0]       kind_q, kind_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;

  logic [WIDTH-1:0] quick_res;
  logic             quick_ill;
  logic [WIDTH-1:0] shifted;
  logic [SHW-1:0]   shamt;

  // Shift amount only uses the low bits of op_b; upper bits are ignored
  assign shamt = op_b[SHW-1:0];

  // Single-cycle op mux; anything not listed here is reported as illegal
  always_comb begin
    quick_res = '0;
    quick_ill = 1'b0;
    case (alu_ctl)
      ALU_ADD: quick_res = op_a + op_b;
      ALU_SUB: quick_res = op_a - op_b;
      ALU_AND: quick_res = op_a & op_b;
      ALU_OR:  quick_res = op_a | op_b;
      default: quick_ill = 1'b1;
    endcase
  end

  // The one shifter sits on the working register and advances it one bit per SHIFT cycle
  alu_shift_step #(
    .WIDTH (WIDTH)
  ) u_shift_step (
    .din  (work_q),
    .kind (kind_q),
    .dout (shifted)
  );

  // Next-state, datapath updates and handshake outputs
  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    cnt_d     = cnt_q;
    kind_d    = kind_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (is_shift_code(alu_ctl)) begin
            work_d    = op_a;
            kind_d    = alu_ctl[1:0];
            cnt_d     = shamt;
            illegal_d = 1'b0;
            zero_d    = (op_a == '0);
            state_d   = (shamt == '0) ? DONE : SHIFT;
          end else begin
            work_d    = quick_res;
            cnt_d     = '0;
            illegal_d = quick_ill;
            zero_d    = (quick_res == '0);
            state_d   = DONE;
          end
        end
      end
      SHIFT: begin
        work_d = shifted;
        cnt_d  = cnt_q - SHW'(1);
        zero_d = (shifted == '0);
        if (cnt_q == SHW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset drops any in-flight op immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Working register, shift count and status flags move together
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      work_q    <= '0;
      cnt_q     <= '0;
      kind_q    <= SK_SLL;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      work_q    <= work_d;
      cnt_q     <= cnt_d;
      kind_q    <= kind_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  assign result  = work_q;
  assign zero    = zero_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: vector table plus reset, backpressure and back-to-back sequences.
// Latency: measured in clock edges from the cycle a request is driven.
// Backpressure: exercised by holding out_ready low while out_valid is high.
module tb_alu_exec_unit;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   alu_ctl;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         illegal;

  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctl   (alu_ctl),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal)
  );

  typedef struct {
    string       name;
    logic [3:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
    logic        ill;
    int          lat;
  } vec_t;

  vec_t vecs[15];
  int   n_chk  = 0;
  int   n_pass = 0;
  time  cap_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle again.
  task automatic run_op(input vec_t v, input int hold, input bit noise);
    int lat;
    bit to;
    out_ready = (hold == 0);
    chk({v.name, " in_ready before"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    alu_ctl  = v.ctl;
    op_a     = v.a;
    op_b     = v.b;
    @(posedge clk);
    cap_t = $time;
    #1;
    if (noise) begin
      in_valid = 1'b1;
      alu_ctl  = ALU_ADD;
      op_a     = $urandom;
      op_b     = $urandom;
    end else begin
      in_valid = 1'b0;
    end
    lat = 1;
    to  = 1'b0;
    while (!out_valid && !to) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat > 100) to = 1'b1;
    end
    in_valid = 1'b0;
    if (to) $display("FAIL %s timeout: out_valid never rose, expected after %0d edges", v.name, v.lat);
    chk({v.name, " latency"}, 32'(lat), 32'(v.lat));
    if (!to) begin
      chk({v.name, " result"},  result, v.res);
      chk({v.name, " zero"},    32'(zero), 32'(v.zero));
      chk({v.name, " illegal"}, 32'(illegal), 32'(v.ill));
      chk({v.name, " in_ready in DONE"}, 32'(in_ready), 32'd0);
      for (int i = 0; i < hold; i++) begin
        if (noise) begin
          in_valid = i[0];
          op_a     = $urandom;
        end
        @(posedge clk);
        #1;
        chk({v.name, " held out_valid"}, 32'(out_valid), 32'd1);
        chk({v.name, " held result"},    result, v.res);
        chk({v.name, " held in_ready"},  32'(in_ready), 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk({v.name, " out_valid after consume"}, 32'(out_valid), 32'd0);
      chk({v.name, " in_ready after consume"},  32'(in_ready), 32'd1);
    end
  endtask

  initial begin
    vec_t v;
    time  t1;
    int   ov_seen;

    vecs[0]  = '{"add 7+5",       ALU_ADD,     32'd7,          32'd5,          32'd12,         1'b0, 1'b0, 1};
    vecs[1]  = '{"sub 5-5",       ALU_SUB,     32'd5,          32'd5,          32'd0,          1'b1, 1'b0, 1};
    vecs[2]  = '{"sub 0-1",       ALU_SUB,     32'd0,          32'd1,          32'hFFFF_FFFF,  1'b0, 1'b0, 1};
    vecs[3]  = '{"and",           ALU_AND,     32'h0000_000F,  32'h0000_003C,  32'h0000_000C,  1'b0, 1'b0, 1};
    vecs[4]  = '{"or",            ALU_OR,      32'h0000_00F0,  32'h0000_000F,  32'h0000_00FF,  1'b0, 1'b0, 1};
    vecs[5]  = '{"sll 1<<31",     ALU_SLL,     32'd1,          32'd31,         32'h8000_0000,  1'b0, 1'b0, 32};
    vecs[6]  = '{"sra neg by 4",  ALU_SRA,     32'h8000_0000,  32'd4,          32'hF800_0000,  1'b0, 1'b0, 5};
    vecs[7]  = '{"srl by 4",      ALU_SRL,     32'h8000_0000,  32'd4,          32'h0800_0000,  1'b0, 1'b0, 5};
    vecs[8]  = '{"srl amount 0",  ALU_SRL,     32'h1234_5678,  32'h0000_0020,  32'h1234_5678,  1'b0, 1'b0, 1};
    vecs[9]  = '{"illegal 1111",  ALU_ILLEGAL, 32'h1234_5678,  32'h0000_0001,  32'd0,          1'b1, 1'b1, 1};
    vecs[10] = '{"illegal 0101",  4'b0101,     32'd3,          32'd4,          32'd0,          1'b1, 1'b1, 1};
    vecs[11] = '{"sll drops msb", ALU_SLL,     32'h8000_0001,  32'd1,          32'h0000_0002,  1'b0, 1'b0, 2};
    vecs[12] = '{"sra pos by 3",  ALU_SRA,     32'h4000_0000,  32'd3,          32'h0800_0000,  1'b0, 1'b0, 4};
    vecs[13] = '{"add wrap",      ALU_ADD,     32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, 1'b0, 1};
    vecs[14] = '{"srl to zero",   ALU_SRL,     32'd1,          32'd1,          32'd0,          1'b1, 1'b0, 2};

    reset     = 1'b1;
    in_valid  = 1'b0;
    alu_ctl   = 4'd0;
    op_a      = '0;
    op_b      = '0;
    out_ready = 1'b1;

    #1;
    chk("reset in_ready",  32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset result",    result, 32'd0);
    chk("reset zero",      32'(zero), 32'd0);
    chk("reset illegal",   32'(illegal), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("idle out_valid", 32'(out_valid), 32'd0);

    for (int i = 0; i < 15; i++) begin
      run_op(vecs[i], 0, 1'b0);
    end

    // Backpressure on a one-cycle op, with in_valid pulses while held
    v = '{"bp add", ALU_ADD, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 1};
    run_op(v, 10, 1'b1);

    // in_valid held high and operands changing during SHIFT
    v = '{"noisy sll", ALU_SLL, 32'd1, 32'd5, 32'd32, 1'b0, 1'b0, 6};
    run_op(v, 3, 1'b1);

    // Reset in the middle of a long shift
    out_ready = 1'b1;
    in_valid  = 1'b1;
    alu_ctl   = ALU_SLL;
    op_a      = 32'd1;
    op_b      = 32'd20;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid-shift out_valid", 32'(out_valid), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("async reset out_valid", 32'(out_valid), 32'd0);
    chk("async reset in_ready",  32'(in_ready), 32'd1);
    chk("async reset result",    result, 32'd0);
    chk("async reset zero",      32'(zero), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    ov_seen = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (out_valid) ov_seen++;
    end
    chk("no out_valid after reset", 32'(ov_seen), 32'd0);
    v = '{"or after reset", ALU_OR, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0, 1'b0, 1};
    run_op(v, 0, 1'b0);

    // Back-to-back one-cycle ops with out_ready tied high
    run_op(vecs[3], 0, 1'b0);
    t1 = cap_t;
    v = '{"b2b or", ALU_OR, 32'h0000_0F00, 32'h0000_000C, 32'h0000_0F0C, 1'b0, 1'b0, 1};
    run_op(v, 0, 1'b0);
    chk("b2b accept spacing", 32'(cap_t - t1), 32'd20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
